// File: rtl/in_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : in_port_fifo
//  Description : Receive FIFO for the "in" instruction. An external device
//                pushes words with a valid/ready handshake. The datapath
//                gates the head word onto the bus while in_port_out is high,
//                and the head is popped when in_port_out falls.
//  Revision    : 1.0 - initial release
// ============================================================================
module in_port_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             Clock,
  input  logic             clr,
  input  logic [WIDTH-1:0] dev_data,
  input  logic             dev_valid,
  output logic             dev_ready,
  input  logic             in_port_out,
  output logic [WIDTH-1:0] BusMuxIn_InPort,
  output logic             in_port_empty,
  output logic [AW:0]      in_port_count,
  output logic             underflow
);

  localparam logic [AW:0] C_FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             r_out_d;
  logic             r_underflow;

  logic             w_push;
  logic             w_pop;

  // Full/empty derive from the occupancy count only, so pointer wrap is harmless.
  // A pop needs a falling edge of in_port_out and something stored; a falling
  // edge while empty (an underflowed read) pops nothing and is not deferred.
  always_comb begin
    dev_ready       = (r_count != C_FULL_COUNT);
    in_port_empty   = (r_count == '0);
    in_port_count   = r_count;
    underflow       = r_underflow;
    w_push          = dev_valid & dev_ready;
    w_pop           = r_out_d & ~in_port_out & ~in_port_empty;
    BusMuxIn_InPort = (in_port_out && !in_port_empty) ? r_mem[r_rptr] : '0;
  end

  // Pointers, occupancy, edge-detect flop and sticky underflow flag.
  always_ff @(posedge Clock or negedge clr) begin
    if (!clr) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_d     <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_out_d <= in_port_out;
      if (in_port_out && in_port_empty) begin
        r_underflow <= 1'b1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Storage array; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= dev_data;
    end
  end

endmodule
`default_nettype wire
